// File: rtl/estagio_writeback.sv
`default_nettype none
// ============================================================================
// Module      : estagio_writeback
// Description : Writeback controller driving the register-file write port.
// Revision    : 1.0
// ============================================================================
module estagio_writeback #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        wb_in_clk,
  input  logic        wb_in_reset_n,
  input  logic        wb_in_valid,
  output logic        wb_out_ready,
  input  logic [31:0] wb_in_IR,
  input  logic [31:0] wb_in_alu_result,
  input  logic [31:0] wb_in_pc,
  input  logic        wb_in_mem_rvalid,
  input  logic [31:0] wb_in_mem_rdata,
  output logic        wb_out_w_en,
  output logic [4:0]  wb_out_rd,
  output logic [31:0] wb_out_data,
  output logic [31:0] wb_out_IR_W,
  output logic        wb_out_err,
  output logic [31:0] wb_out_retired
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_WAIT_LOAD = 2'd2;
  localparam logic [7:0] TO_LAST     = 8'(LOAD_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        w_en_q, w_en_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ir_w_q, ir_w_d;
  logic        err_q, err_d;
  logic [31:0] retired_q, retired_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [31:0] ld_ir_q, ld_ir_d;

  logic        dec_we;
  logic        dec_lw;
  logic [4:0]  dec_rd;
  logic [31:0] dec_data;
  logic        accept;
  logic        timeout;

  assign accept  = wb_in_valid && (state_q == S_IDLE);
  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    dec_we   = 1'b0;
    dec_lw   = 1'b0;
    dec_rd   = 5'd0;
    dec_data = wb_in_alu_result;
    case (wb_in_IR[31:26])
      6'h00: begin
        if (wb_in_IR[5:0] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A}) begin
          dec_we = 1'b1;
          dec_rd = wb_in_IR[15:11];
        end
      end
      6'h08: begin
        dec_we = 1'b1;
        dec_rd = wb_in_IR[20:16];
      end
      6'h23: begin
        dec_lw = 1'b1;
        dec_rd = wb_in_IR[20:16];
      end
      6'h03: begin
        dec_we   = 1'b1;
        dec_rd   = 5'd31;
        dec_data = wb_in_pc + 32'd8;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_in_clk or negedge wb_in_reset_n) begin
    if (!wb_in_reset_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = dec_lw ? S_WAIT_LOAD : S_WRITE;
      S_WRITE:     state_d = S_IDLE;
      S_WAIT_LOAD: begin
        if (wb_in_mem_rvalid) state_d = S_WRITE;
        else if (timeout)     state_d = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Write-port outputs are registered on the edge that enters WRITE and hold otherwise.
  always_comb begin
    w_en_d    = 1'b0;
    err_d     = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    ir_w_d    = ir_w_q;
    retired_d = retired_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_ir_d   = ld_ir_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (accept) begin
          if (dec_lw) begin
            ld_rd_d = dec_rd;
            ld_ir_d = wb_in_IR;
          end else if (dec_we) begin
            rd_d   = dec_rd;
            data_d = dec_data;
            ir_w_d = wb_in_IR;
            w_en_d = (dec_rd != 5'd0);
          end
        end
      end
      S_WRITE: retired_d = retired_q + 32'd1;
      S_WAIT_LOAD: begin
        if (wb_in_mem_rvalid) begin
          rd_d   = ld_rd_q;
          data_d = wb_in_mem_rdata;
          ir_w_d = ld_ir_q;
          w_en_d = (ld_rd_q != 5'd0);
          cnt_d  = 8'd0;
        end else if (timeout) begin
          err_d = 1'b1;
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_in_clk or negedge wb_in_reset_n) begin
    if (!wb_in_reset_n) begin
      w_en_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= 32'd0;
      ir_w_q    <= 32'd0;
      retired_q <= 32'd0;
      cnt_q     <= 8'd0;
      ld_rd_q   <= 5'd0;
      ld_ir_q   <= 32'd0;
    end else begin
      w_en_q    <= w_en_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      ir_w_q    <= ir_w_d;
      retired_q <= retired_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_ir_q   <= ld_ir_d;
    end
  end

  assign wb_out_ready   = (state_q == S_IDLE);
  assign wb_out_w_en    = w_en_q;
  assign wb_out_err     = err_q;
  assign wb_out_rd      = rd_q;
  assign wb_out_data    = data_q;
  assign wb_out_IR_W    = ir_w_q;
  assign wb_out_retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_estagio_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_estagio_writeback
// Description : Directed bench for estagio_writeback (LOAD_TIMEOUT = 4).
// Revision    : 1.0
// ============================================================================
module tb_estagio_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] ir = '0, alu = '0, pc = '0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        w_en;
  logic [4:0]  rd;
  logic [31:0] data, ir_w, retired;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0, m_ir = '0, m_ret = '0;

  estagio_writeback #(.LOAD_TIMEOUT(4)) dut (
    .wb_in_clk(clk), .wb_in_reset_n(rst_n), .wb_in_valid(valid), .wb_out_ready(ready),
    .wb_in_IR(ir), .wb_in_alu_result(alu), .wb_in_pc(pc),
    .wb_in_mem_rvalid(rvalid), .wb_in_mem_rdata(rdata),
    .wb_out_w_en(w_en), .wb_out_rd(rd), .wb_out_data(data), .wb_out_IR_W(ir_w),
    .wb_out_err(err), .wb_out_retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        upd;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input logic [31:0] i_ir, input logic [31:0] i_alu, input logic [31:0] i_pc);
    @(negedge clk);
    valid = 1'b1; ir = i_ir; alu = i_alu; pc = i_pc;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".rd"},   32'(rd),  32'(m_rd));
    chk({tag, ".data"}, data,     m_data);
    chk({tag, ".irw"},  ir_w,     m_ir);
  endtask

  task automatic wait_load(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      chk("wait.ready", 32'(ready), 32'd0);
      chk("wait.err",   32'(err),   32'd0);
      chk("wait.wen",   32'(w_en),  32'd0);
    end
  endtask

  task automatic load_resp(input logic [31:0] d, input logic [4:0] exp_rd, input logic [31:0] exp_ir);
    @(negedge clk);
    rvalid = 1'b1; rdata = d;
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    m_rd = exp_rd; m_data = d; m_ir = exp_ir;
    chk("lw.wen", 32'(w_en), 32'(exp_rd != 5'd0));
    chk("lw.err", 32'(err),  32'd0);
    chk_outs("lw");
    @(posedge clk);
    #1;
    m_ret = m_ret + 1;
    chk("lw.wen_off", 32'(w_en), 32'd0);
    chk("lw.retired", retired, m_ret);
    chk("lw.ready",   32'(ready), 32'd1);
  endtask

  initial begin
    //            ir            alu           pc            upd  we   rd     data
    vecs[0]  = '{32'h012A4020, 32'd5,        32'h0,        1'b1, 1'b1, 5'd8,  32'd5};
    vecs[1]  = '{32'h0C000010, 32'h0,        32'h00400000, 1'b1, 1'b1, 5'd31, 32'h00400008};
    vecs[2]  = '{32'h20000007, 32'd7,        32'h0,        1'b1, 1'b0, 5'd0,  32'd7};
    vecs[3]  = '{32'hAC080000, 32'h99,       32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
    vecs[4]  = '{32'h21090003, 32'h1234,     32'h0,        1'b1, 1'b1, 5'd9,  32'h1234};
    vecs[5]  = '{32'h0109502A, 32'd1,        32'h0,        1'b1, 1'b1, 5'd10, 32'd1};
    vecs[6]  = '{32'h03E00008, 32'h55,       32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
    vecs[7]  = '{32'h01095026, 32'h66,       32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
    vecs[8]  = '{32'h01090024, 32'hAA,       32'h0,        1'b1, 1'b0, 5'd0,  32'hAA};
    vecs[9]  = '{32'h0C000000, 32'h0,        32'hFFFFFFFC, 1'b1, 1'b1, 5'd31, 32'h00000004};
    vecs[10] = '{32'h11090004, 32'h77,       32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
    vecs[11] = '{32'h01095023, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b1, 5'd10, 32'hFFFFFFFF};

    repeat (2) @(negedge clk);
    chk("rst.ready",   32'(ready), 32'd1);
    chk("rst.wen",     32'(w_en),  32'd0);
    chk("rst.err",     32'(err),   32'd0);
    chk("rst.retired", retired,    32'd0);
    chk_outs("rst");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].ir, vecs[i].alu, vecs[i].pc);
      if (vecs[i].upd) begin
        m_rd = vecs[i].rd; m_data = vecs[i].data; m_ir = vecs[i].ir;
      end
      chk($sformatf("v%0d.ready", i), 32'(ready), 32'd0);
      chk($sformatf("v%0d.wen", i),   32'(w_en),  32'(vecs[i].we));
      chk($sformatf("v%0d.err", i),   32'(err),   32'd0);
      chk_outs($sformatf("v%0d", i));
      @(posedge clk);
      #1;
      m_ret = m_ret + 1;
      chk($sformatf("v%0d.wen_off", i), 32'(w_en),  32'd0);
      chk($sformatf("v%0d.retired", i), retired,    m_ret);
      chk($sformatf("v%0d.ready2", i),  32'(ready), 32'd1);
    end

    // lw: rvalid on the third WAIT_LOAD edge
    apply(32'h8C100004, 32'h0, 32'h0);
    chk("lw.ready0", 32'(ready), 32'd0);
    wait_load(2);
    load_resp(32'hDEADBEEF, 5'd16, 32'h8C100004);

    // lw: rvalid on the same edge the counter expires
    apply(32'h8C110008, 32'h0, 32'h0);
    wait_load(3);
    load_resp(32'hCAFEF00D, 5'd17, 32'h8C110008);

    // lw with no response: abort after four WAIT_LOAD cycles
    apply(32'h8C120000, 32'h0, 32'h0);
    wait_load(3);
    @(posedge clk);
    #1;
    chk("to.err",     32'(err),   32'd1);
    chk("to.wen",     32'(w_en),  32'd0);
    chk("to.ready",   32'(ready), 32'd1);
    chk("to.retired", retired,    m_ret);
    chk_outs("to");
    @(posedge clk);
    #1;
    chk("to.err_off", 32'(err), 32'd0);

    // stray rvalid in IDLE is ignored
    load_stray: begin
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'h12345678;
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      chk("idle_rv.wen",   32'(w_en),  32'd0);
      chk("idle_rv.ready", 32'(ready), 32'd1);
      chk_outs("idle_rv");
    end

    // reset during WAIT_LOAD discards the load
    apply(32'h8C130000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_rd = '0; m_data = '0; m_ir = '0; m_ret = '0;
    chk("mrst.ready",   32'(ready), 32'd1);
    chk("mrst.wen",     32'(w_en),  32'd0);
    chk("mrst.retired", retired,    32'd0);
    chk_outs("mrst");
    rvalid = 1'b1; rdata = 32'h0BADF00D;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    chk("mrst.wen2",   32'(w_en),  32'd0);
    chk("mrst.ready2", 32'(ready), 32'd1);
    chk_outs("mrst2");

    // retired counter wraps
    @(negedge clk);
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    #1;
    chk("wrap.pre", retired, 32'hFFFFFFFF);
    apply(32'hAC080000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("wrap.post", retired, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
